// File: rtl/matmul_sequencer.sv
// Sequencer for an external P x P matrix-multiply coefficient unit: issues row/column
// operand pairs in row-major order and collects the dot-product results into C.
module matmul_sequencer #(
    parameter int N   = 32,
    parameter int Q   = 18,
    parameter int P   = 4,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [P*P*N-1:0] A,
    input  logic [P*P*N-1:0] B,
    output logic [P*N-1:0]   lineA,
    output logic [P*N-1:0]   columnB,
    input  logic [N-1:0]     cii,
    input  logic             overflow_in,
    output logic [P*P*N-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int NE = P * P;
    localparam int CW = $clog2(NE);
    localparam int RW = $clog2(P);
    localparam logic [CW-1:0] LAST_IDX = CW'(NE - 1);
    localparam logic [RW-1:0] LAST_RC  = RW'(P - 1);

    // Q describes the fixed-point format of the data only; it never enters the logic.
    if (LAT < 1 || LAT > 8 || P < 2 || Q < 0 || Q >= N) begin : g_param_check
        $error("matmul_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [NE*N-1:0]         a_q, a_d, b_q, b_d, c_q, c_d;
    logic [P*N-1:0]          line_q, line_d, col_q, col_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           row_q, row_d, colx_q, colx_d;
    logic [RW-1:0]           nrow, ncol;
    logic [LAT-1:0]          vld_q, vld_d;
    logic [LAT-1:0][CW-1:0]  idx_q, idx_d;
    logic                    ovf_q, ovf_d, done_q, done_d;
    logic                    capture;
    logic [CW-1:0]           cap_idx;

    function automatic logic [P*N-1:0] row_of(input logic [NE*N-1:0] m, input logic [RW-1:0] r);
        logic [P*N-1:0] v;
        v = '0;
        for (int i = 0; i < P; i++)
            if (r == RW'(i)) v = m[i*P*N +: P*N];
        return v;
    endfunction

    function automatic logic [P*N-1:0] col_of(input logic [NE*N-1:0] m, input logic [RW-1:0] c);
        logic [P*N-1:0] v;
        v = '0;
        for (int j = 0; j < P; j++)
            if (c == RW'(j))
                for (int r = 0; r < P; r++) v[r*N +: N] = m[(r*P+j)*N +: N];
        return v;
    endfunction

    // The oldest pipeline stage marks the pair whose result is on cii this cycle.
    assign capture = vld_q[LAT-1];
    assign cap_idx = idx_q[LAT-1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        line_d  = line_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        colx_d  = colx_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        nrow    = row_q;
        ncol    = colx_q + RW'(1);
        if (colx_q == LAST_RC) begin
            nrow = row_q + RW'(1);
            ncol = '0;
        end

        vld_d[0] = (state_q == ISSUE);
        idx_d[0] = cnt_q;
        for (int d = 1; d < LAT; d++) begin
            vld_d[d] = vld_q[d-1];
            idx_d[d] = idx_q[d-1];
        end

        if (capture) begin
            for (int k = 0; k < NE; k++)
                if (cap_idx == CW'(k)) c_d[k*N +: N] = cii;
            ovf_d = ovf_q | overflow_in;
        end

        case (state_q)
            IDLE: begin
                // The done cycle also blocks start, so a new product begins one cycle later.
                if (start && !done_q) begin
                    a_d     = A;
                    b_d     = B;
                    ovf_d   = 1'b0;
                    line_d  = row_of(A, '0);
                    col_d   = col_of(B, '0);
                    cnt_d   = '0;
                    row_d   = '0;
                    colx_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    row_d  = nrow;
                    colx_d = ncol;
                    line_d = row_of(a_q, nrow);
                    col_d  = col_of(b_q, ncol);
                end
            end
            DRAIN: begin
                if (capture && cap_idx == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: operand copies and C are plain flops, so they are cleared by reset like any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            line_q  <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            colx_q  <= '0;
            vld_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state updates are non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            line_q  <= line_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            colx_q  <= colx_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign lineA    = line_q;
    assign columnB  = col_q;
    assign C        = c_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: expected products are queued at start
// and compared against C/overflow when done pulses, with an exact dot-product model.
module tb_matmul_sequencer;
    localparam int N       = 32;
    localparam int Q       = 0;
    localparam int P       = 4;
    localparam int LAT     = 2;
    localparam int NE      = P * P;
    localparam int MW      = NE * N;
    localparam int VW      = P * N;
    localparam int DONE_AT = NE + LAT + 1;

    typedef logic [MW-1:0] mat_t;
    typedef logic [VW-1:0] vec_t;
    typedef struct {
        mat_t c;
        logic ovf;
        int   done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start, overflow_in;
    mat_t         A, B, C;
    vec_t         lineA, columnB;
    logic [N-1:0] cii;
    logic         busy, done, overflow;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [N-1:0] cpipe [0:LAT];

    matmul_sequencer #(.N(N), .Q(Q), .P(P), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .lineA(lineA), .columnB(columnB), .cii(cii), .overflow_in(overflow_in),
        .C(C), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input mat_t got, input mat_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic signed [N-1:0] el(input mat_t m, input int r, input int c);
        return m[(r*P+c)*N +: N];
    endfunction

    function automatic mat_t put(input mat_t m, input int r, input int c, input int v);
        mat_t t;
        t = m;
        t[(r*P+c)*N +: N] = N'(v);
        return t;
    endfunction

    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t m;
        m = '0;
        for (int i = 0; i < P; i++)
            for (int j = 0; j < P; j++) begin
                longint s;
                s = 0;
                for (int r = 0; r < P; r++) s += longint'(el(a, i, r)) * longint'(el(b, r, j));
                m = put(m, i, j, int'(s));
            end
        return m;
    endfunction

    function automatic logic [N-1:0] dot(input vec_t x, input vec_t y);
        longint s;
        s = 0;
        for (int c = 0; c < P; c++)
            s += longint'($signed(x[c*N +: N])) * longint'($signed(y[c*N +: N]));
        return s[N-1:0];
    endfunction

    function automatic vec_t row_exp(input mat_t m, input int i);
        return m[i*VW +: VW];
    endfunction

    function automatic vec_t col_exp(input mat_t m, input int j);
        vec_t v;
        for (int r = 0; r < P; r++) v[r*N +: N] = m[(r*P+j)*N +: N];
        return v;
    endfunction

    // Coefficient unit model: result appears LAT cycles after its operands.
    always @(negedge clk) begin
        for (int d = LAT; d > 0; d--) cpipe[d] = cpipe[d-1];
        cpipe[0] = dot(lineA, columnB);
        cii = cpipe[LAT];
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("C", C, e.c);
                check("overflow", overflow, e.ovf);
            end
        end
    end

    task automatic start_product(input mat_t a, input mat_t b, input logic ovf);
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back('{c: matmul(a, b), ovf: ovf, done_cyc: cyc + DONE_AT});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mat_t ident, bseq, arow, bcol, ra, rb, ra2, rb2, prev;
        ident = '0; bseq = '0; arow = '0; bcol = '0;
        ra = '0; rb = '0; ra2 = '0; rb2 = '0;
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++) begin
                ident = put(ident, r, c, (r == c) ? 1 : 0);
                bseq  = put(bseq, r, c, r*4 + c);
                arow  = put(arow, r, c, r + 1);
                bcol  = put(bcol, r, c, c + 1);
                ra    = put(ra,  r, c, int'($urandom_range(200)) - 100);
                rb    = put(rb,  r, c, int'($urandom_range(200)) - 100);
                ra2   = put(ra2, r, c, int'($urandom_range(200)) - 100);
                rb2   = put(rb2, r, c, int'($urandom_range(200)) - 100);
            end
        reset = 1'b0; start = 1'b0; A = '0; B = '0; overflow_in = 1'b0;
        for (int d = 0; d <= LAT; d++) cpipe[d] = '0;
        cii = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_C", C, '0);
        check("rst_lineA", lineA, '0);
        check("rst_columnB", columnB, '0);

        // Identity, started on the first edge after reset release
        @(negedge clk);
        reset = 1'b1;
        start_product(ident, bseq, 1'b0);
        check("busy_c0", busy, 1'b0);
        for (int t = 1; t <= DONE_AT; t++) begin
            @(negedge clk);
            start = 1'b0;
            check("id_busy", busy, t <= NE + LAT);
            check("id_done", done, t == DONE_AT);
        end
        wait_drain();
        check("id_C_eq_B", C, bseq);

        // Ordering of issued operand pairs
        @(negedge clk);
        start_product(arow, bcol, 1'b0);
        for (int k = 0; k < NE; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("lineA", lineA, row_exp(arow, k / P));
            check("columnB", columnB, col_exp(bcol, k % P));
        end
        wait_drain();
        check("c33", C[(NE-1)*N +: N], 64);
        check("lineA_hold", lineA, row_exp(arow, P - 1));
        check("columnB_hold", columnB, col_exp(bcol, P - 1));

        // Overflow only in the capture cycle of pair 7
        @(negedge clk);
        start_product(ra, rb, 1'b1);
        for (int t = 1; t <= DONE_AT; t++) begin
            @(negedge clk);
            start = 1'b0;
            overflow_in = (t == 1 + 7 + LAT);
        end
        overflow_in = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("ovf_hold", overflow, 1'b1);
        prev = C;

        // Next product: overflow cleared, C retained, off-capture overflow_in ignored
        @(negedge clk);
        start_product(rb, ra, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("ovf_clear", overflow, 1'b0);
        check("C_retained", C, prev);
        overflow_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        overflow_in = 1'b0;
        wait_drain();

        // Start while busy is ignored
        @(negedge clk);
        start_product(ra, rb, 1'b0);
        for (int t = 1; t <= DONE_AT; t++) begin
            @(negedge clk);
            start = (t == 5);
            if (t == 5) begin
                A = ra2;
                B = rb2;
            end
        end
        wait_drain();
        repeat (DONE_AT + 5) @(negedge clk);

        // Mid-operation reset
        @(negedge clk);
        start_product(ra2, rb2, 1'b0);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        sb.delete();
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_C", C, '0);
        check("mid_lineA", lineA, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (DONE_AT + 5) @(negedge clk);
        @(negedge clk);
        start_product(ra2, rb2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Back-to-back with start held high; operands change at cycle 3
        @(negedge clk);
        start_product(arow, bcol, 1'b0);
        for (int t = 1; t <= DONE_AT + 1; t++) begin
            @(negedge clk);
            if (t == 3) begin
                A = ra;
                B = rb;
            end
            if (t == DONE_AT + 1) start_product(ra, rb, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
